// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES encryption-core scheduler.
// Holds the block type, the scheduler state encoding and the fixed core latency.
package aes_sched_pkg;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } sched_state_t;

    localparam int AES_LAT = 11;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or above ptr,
// wrapping around; no grant while en is low.
module aes_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] rot_req;
    logic [NUM_REQ-1:0] rot_gnt;

    // Rotate so ptr sits at bit 0, pick the lowest set bit, then rotate back
    always_comb begin
        rot_req = NUM_REQ'({req, req} >> ptr);
        rot_gnt = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                rot_gnt    = '0;
                rot_gnt[i] = 1'b1;
            end
        end
        grant = en ? NUM_REQ'(({rot_gnt, rot_gnt} << ptr) >> NUM_REQ) : '0;
    end

endmodule

// File: rtl/aes_enc_sched.sv
// Round-robin scheduler sharing one AES encryption core between NUM_REQ requesters.
// Optional core-timeout watchdog (err_timeout port) enabled by AES_SCHED_WATCHDOG_EN.
module aes_enc_sched
    import aes_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0][127:0] req_data,
    input  logic [NUM_REQ-1:0][127:0] req_key,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [127:0]              rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      core_data_valid,
    output logic [127:0]              core_data,
    output logic [127:0]              core_key,
    input  logic                      core_res_valid,
    input  logic [127:0]              core_res,
`ifdef AES_SCHED_WATCHDOG_EN
    output logic                      err_timeout,
`endif
    output logic                      busy
);

    sched_state_t       state;
    sched_state_t       state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    in_flight_id;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               can_issue;
    logic               accept;
    logic               wd_expire;
    aes_block_t         sel_data;
    aes_block_t         sel_key;

    // No grants during reset, so no requester sees a handshake that gets discarded
    assign can_issue = !reset && ((state == IDLE) || (state == RESP && rsp_ready));

    aes_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .en   (can_issue),
        .grant(grant)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = ID_W'(i);
        end
    end

    assign sel_data        = req_data[grant_idx];
    assign sel_key         = req_key[grant_idx];
    assign core_data_valid = accept;
    assign core_data       = accept ? sel_data : '0;
    assign core_key        = accept ? sel_key  : '0;
    assign rsp_valid       = (state == RESP);
    assign busy            = (state != IDLE);

`ifdef AES_SCHED_WATCHDOG_EN
    logic [3:0] wd_cnt;

    // wd_cnt equals cycles since accept; the result is overdue once it would pass AES_LAT
    assign wd_expire = (state == BUSY) && !core_res_valid && (wd_cnt == 4'(AES_LAT));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= wd_expire;
            if (accept) begin
                wd_cnt <= 4'd1;
            end else if (state == BUSY) begin
                wd_cnt <= wd_cnt + 4'd1;
            end
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = BUSY;
            BUSY: begin
                if (core_res_valid) begin
                    state_nxt = RESP;
                end else if (wd_expire) begin
                    state_nxt = IDLE;
                end
            end
            RESP: if (rsp_ready) state_nxt = accept ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            in_flight_id <= '0;
            rsp_data     <= '0;
            rsp_id       <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rr_ptr       <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                in_flight_id <= grant_idx;
            end
            if (state == BUSY && core_res_valid) begin
                rsp_data <= core_res;
                rsp_id   <= in_flight_id;
            end
        end
    end

endmodule

// File: tb/tb_aes_enc_sched.sv
// Directed self-checking bench for aes_enc_sched with a fixed-latency core model.
// Watchdog checks run only when AES_SCHED_WATCHDOG_EN is defined.
module tb_aes_enc_sched;

    localparam int           NUM_REQ = 4;
    localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0][127:0] req_data;
    logic [NUM_REQ-1:0][127:0] req_key;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [127:0]              rsp_data;
    logic [1:0]                rsp_id;
    logic                      core_data_valid;
    logic [127:0]              core_data;
    logic [127:0]              core_key;
    logic                      core_res_valid;
    logic [127:0]              core_res;
    logic                      busy;
`ifdef AES_SCHED_WATCHDOG_EN
    logic                      err_timeout;
`endif

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [3:0] core_cnt = 4'd0;
    logic [127:0] core_out;
    logic       core_kill;

    aes_enc_sched #(
        .NUM_REQ(NUM_REQ)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .req_key        (req_key),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_id         (rsp_id),
        .core_data_valid(core_data_valid),
        .core_data      (core_data),
        .core_key       (core_key),
        .core_res_valid (core_res_valid),
        .core_res       (core_res),
`ifdef AES_SCHED_WATCHDOG_EN
        .err_timeout    (err_timeout),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the core: known FIPS-197 vector, otherwise a simple mix; result 11 cycles after issue
    function automatic logic [127:0] coreFn(input logic [127:0] d, input logic [127:0] k);
        if (d == PT_C1 && k == KEY_C1) return CT_C1;
        return d ^ {k[63:0], k[127:64]};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            core_cnt <= 4'd0;
        end else if (core_data_valid) begin
            core_cnt <= 4'd11;
            core_out <= coreFn(core_data, core_key);
        end else if (core_cnt != 4'd0) begin
            core_cnt <= core_cnt - 4'd1;
        end
    end

    assign core_res_valid = (core_cnt == 4'd1) && !core_kill;
    assign core_res       = core_res_valid ? core_out : '0;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic rrdy);
        req_valid = valid;
        rsp_ready = rrdy;
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitAccept(input int bound, output int idx, output int at);
        idx = -1;
        at  = -1;
        for (int k = 0; k < bound; k++) begin
            if (|(req_valid & req_ready)) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (req_ready[j]) idx = j;
                end
                at = cyc;
                break;
            end
            @(negedge clk);
            #1;
        end
        checkOutput("accept_seen", 128'(idx >= 0), 128'd1);
    endtask

    task automatic waitRsp(input int bound);
        bit seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checkOutput("rsp_seen", 128'(seen), 128'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int idx;
        int t;
        int t_prev;
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        core_kill = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i] = {32'hA5A5_0000 + 32'(i), 96'h0123456789abcdeffedcba98};
            req_key[i]  = {96'h00112233445566778899aabb, 32'h0000_1000 + 32'(i)};
        end
        req_data[0] = PT_C1;
        req_key[0]  = KEY_C1;

        // Reset state
        tick(2);
        #1;
        checkOutput("rst_req_ready", 128'(req_ready), 128'd0);
        checkOutput("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        checkOutput("rst_busy", 128'(busy), 128'd0);
        checkOutput("rst_rsp_data", rsp_data, 128'd0);
        checkOutput("rst_rsp_id", 128'(rsp_id), 128'd0);
        checkOutput("rst_core_valid", 128'(core_data_valid), 128'd0);
        checkOutput("rst_core_data", core_data, 128'd0);
        checkOutput("rst_core_key", core_key, 128'd0);
`ifdef AES_SCHED_WATCHDOG_EN
        checkOutput("rst_err_timeout", 128'(err_timeout), 128'd0);
`endif
        tick(1);
        reset = 1'b0;

        // Single FIPS-197 C.1 request on requester 0
        tick(1);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("c1_req_ready", 128'(req_ready), 128'h1);
        checkOutput("c1_core_valid", 128'(core_data_valid), 128'd1);
        checkOutput("c1_core_data", core_data, PT_C1);
        checkOutput("c1_core_key", core_key, KEY_C1);
        tick(1);
        applyStimulus(4'b0010, 1'b0);
        checkOutput("c1_busy", 128'(busy), 128'd1);
        checkOutput("c1_no_grant_busy", 128'(req_ready), 128'd0);
        checkOutput("c1_core_valid_off", 128'(core_data_valid), 128'd0);
        checkOutput("c1_core_data_off", core_data, 128'd0);
        tick(10);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("c1_no_rsp_t11", 128'(rsp_valid), 128'd0);
        tick(1);
        #1;
        checkOutput("c1_rsp_valid_t12", 128'(rsp_valid), 128'd1);
        checkOutput("c1_rsp_data", rsp_data, CT_C1);
        checkOutput("c1_rsp_id", 128'(rsp_id), 128'd0);
        tick(1);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("c1_rsp_held", 128'(rsp_valid), 128'd1);
        tick(1);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("c1_rsp_drained", 128'(rsp_valid), 128'd0);
        checkOutput("c1_idle", 128'(busy), 128'd0);

        // Fairness: all requesters valid from rr_ptr=0
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        applyStimulus(4'b1111, 1'b1);
        t_prev = 0;
        for (int i = 0; i < 5; i++) begin
            waitAccept(20, idx, t);
            checkOutput("fair_grant", 128'(idx), 128'(i % 4));
            checkOutput("fair_core_data", core_data, req_data[i % 4]);
            if (i > 0) begin
                checkOutput("fair_spacing", 128'(t - t_prev), 128'd12);
                checkOutput("fair_rsp_valid", 128'(rsp_valid), 128'd1);
                checkOutput("fair_rsp_id", 128'(rsp_id), 128'((i - 1) % 4));
                checkOutput("fair_rsp_data", rsp_data, coreFn(req_data[(i - 1) % 4], req_key[(i - 1) % 4]));
            end
            t_prev = t;
            tick(1);
            #1;
        end
        applyStimulus(4'b0000, 1'b1);
        waitRsp(20);
        checkOutput("fair_last_id", 128'(rsp_id), 128'd0);
        checkOutput("fair_last_data", rsp_data, CT_C1);
        tick(1);

        // Backpressure: result from requester 1 held while requester 2 waits
        applyStimulus(4'b0010, 1'b0);
        waitAccept(4, idx, t);
        checkOutput("bp_grant", 128'(idx), 128'd1);
        tick(1);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("bp_wait_ready", 128'(req_ready), 128'd0);
        waitRsp(20);
        checkOutput("bp_rsp_id", 128'(rsp_id), 128'd1);
        for (int k = 0; k < 20; k++) begin
            tick(1);
            #1;
            checkOutput("bp_hold_valid", 128'(rsp_valid), 128'd1);
            checkOutput("bp_hold_data", rsp_data, coreFn(req_data[1], req_key[1]));
            checkOutput("bp_hold_id", 128'(rsp_id), 128'd1);
            checkOutput("bp_hold_ready", 128'(req_ready), 128'd0);
        end
        tick(1);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("bp_release_ready", 128'(req_ready), 128'b0100);
        checkOutput("bp_release_core_valid", 128'(core_data_valid), 128'd1);
        checkOutput("bp_release_core_data", core_data, req_data[2]);
        tick(1);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("bp_next_busy", 128'(busy), 128'd1);
        checkOutput("bp_rsp_consumed", 128'(rsp_valid), 128'd0);

        // Wrap: after requester 3, only 1 and 3 valid -> requester 1
        waitRsp(20);
        checkOutput("wrap_prev_id", 128'(rsp_id), 128'd2);
        tick(1);
        applyStimulus(4'b1010, 1'b1);
        waitAccept(4, idx, t);
        checkOutput("wrap_grant3", 128'(idx), 128'd3);
        tick(1);
        #1;
        waitAccept(20, idx, t);
        checkOutput("wrap_grant1", 128'(idx), 128'd1);
        tick(1);
        applyStimulus(4'b0000, 1'b1);
        waitRsp(20);
        checkOutput("wrap_rsp_id", 128'(rsp_id), 128'd1);
        tick(1);
        #1;

        // Reset five cycles into an in-flight block from requester 2
        applyStimulus(4'b0100, 1'b1);
        waitAccept(4, idx, t);
        checkOutput("rstmid_grant", 128'(idx), 128'd2);
        tick(1);
        applyStimulus(4'b0000, 1'b1);
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        #1;
        checkOutput("rstmid_busy", 128'(busy), 128'd0);
        checkOutput("rstmid_rsp_valid", 128'(rsp_valid), 128'd0);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            #1;
            checkOutput("rstmid_no_rsp", 128'(rsp_valid), 128'd0);
        end
        applyStimulus(4'b1010, 1'b1);
        checkOutput("rstmid_ptr0_grant", 128'(req_ready), 128'b0010);
        tick(1);
        applyStimulus(4'b0000, 1'b1);
        waitRsp(20);
        checkOutput("rstmid_rsp_id", 128'(rsp_id), 128'd1);
        tick(1);
        #1;

`ifdef AES_SCHED_WATCHDOG_EN
        // Watchdog: core never answers
        core_kill = 1'b1;
        applyStimulus(4'b0001, 1'b0);
        waitAccept(4, idx, t);
        checkOutput("wd_grant", 128'(idx), 128'd0);
        tick(1);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("wd_err_early", 128'(err_timeout), 128'd0);
        tick(10);
        #1;
        checkOutput("wd_err_t11", 128'(err_timeout), 128'd0);
        checkOutput("wd_busy_t11", 128'(busy), 128'd1);
        tick(1);
        #1;
        checkOutput("wd_err_t12", 128'(err_timeout), 128'd1);
        checkOutput("wd_idle_t12", 128'(busy), 128'd0);
        checkOutput("wd_no_rsp_t12", 128'(rsp_valid), 128'd0);
        tick(1);
        #1;
        checkOutput("wd_err_pulse_end", 128'(err_timeout), 128'd0);
        checkOutput("wd_no_rsp_t13", 128'(rsp_valid), 128'd0);
        core_kill = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_enc_sched.md
Name: aes_enc_sched

Overview:
- Round-robin scheduler that shares one aes_enc_top core between NUM_REQ requesters.
- Issues at most one block at a time to the core and captures the single-cycle core result in a one-entry response register.
- Returns each result with the ID of the requester that issued it.
- Sits directly in front of the core. The integrator drives the core's resetn from ~reset.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ): width of the response ID; derived, not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_data  in  NUM_REQ×128  per-requester plaintext
- req_key  in  NUM_REQ×128  per-requester key
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  128  ciphertext
- rsp_id  out  ID_W  index of the requester that issued the block
- core_data_valid  out  1  to core data_valid_in
- core_data  out  128  to core data_in
- core_key  out  128  to core key_in
- core_res_valid  in  1  from core res_valid_out
- core_res  in  128  from core res_enc_out
- busy  out  1  high in any state other than IDLE

Behaviour:
- States:
  - IDLE: no block in flight, response slot empty.
  - BUSY: one block in the core.
  - RESP: result held, rsp_valid=1.
- Reset values: state=IDLE, rr_ptr=0, all outputs 0, rsp_data=0, rsp_id=0.
- Issue condition: can_issue = (state==IDLE) || (state==RESP && rsp_ready).
  - A new block is never issued while the core is busy; the core corrupts its state if data_valid_in arrives mid-encryption.
- Arbitration:
  - Grant goes to the first requester with req_valid, searching from rr_ptr upward with wrap-around.
  - req_ready[g]=can_issue for the granted index g only. Combinational; depends on req_valid.
  - Accept = req_valid[g] && req_ready[g].
  - On accept: rr_ptr <= (g+1) mod NUM_REQ; in_flight_id <= g.
- Core drive, in the accept cycle only:
  - core_data_valid=1, core_data=req_data[g], core_key=req_key[g].
  - In all other cycles: core_data_valid=0, and core_data/core_key are 0.
- Latency: accept at cycle t → core_res_valid at t+11 (fixed core latency, AES_LAT=11).
- Result capture: while in BUSY, core_res_valid=1 → rsp_data<=core_res, rsp_id<=in_flight_id, state→RESP.
- rsp_valid is high in RESP and stays stable until rsp_ready is high.
- Transitions:
  - IDLE→BUSY on accept.
  - BUSY→RESP on core_res_valid.
  - RESP→IDLE on rsp_ready with no accept.
  - RESP→BUSY on rsp_ready with a same-cycle accept (back-to-back).
- Peak throughput: one block per 12 cycles.
- Stray core_res_valid outside BUSY is ignored.
- Requests from non-granted requesters wait. A requester may drop req_valid before it is granted without side effects.
- Reset mid-operation: state returns to IDLE, the in-flight result is discarded, and rr_ptr returns to 0. The core is reset in the same cycle.

Optional Feature:
- AES_SCHED_WATCHDOG_EN
- Defined:
  - A 4-bit counter clears on accept and increments every cycle in BUSY.
  - If the counter reaches AES_LAT+1 without core_res_valid, the block returns IDLE.
  - It then pulses output err_timeout for 1 cycle and produces no response.
  - err_timeout resets to 0.
- Undefined: no counter and no err_timeout port; BUSY waits indefinitely for core_res_valid.

Decomposition:
- Package aes_sched_pkg: aes_block_t (128b), sched_state_t enum {IDLE, BUSY, RESP}, localparam AES_LAT=11.
- Sub-module aes_rr_arbiter (NUM_REQ; inputs req, ptr, en; output one-hot grant).

Test Plan:
- Single request, FIPS-197 C.1: req 0, key 000102…0f, pt 00112233…eeff.
  - Expect accept at t, core_data_valid pulse at t, rsp_valid at t+12.
  - Expect rsp_data = core result (69c4e0d86a7b0430d8cdb78070b4c55a), rsp_id=0.
- Fairness: all 4 requesters held valid, rsp_ready=1.
  - Expect grants 0,1,2,3,0 with accepts spaced exactly 12 cycles apart.
- Backpressure: rsp_ready=0 for 20 cycles after a result while req 2 is valid.
  - Expect rsp_valid/rsp_data/rsp_id stable, req_ready=0.
  - Expect accept of req 2 in the same cycle rsp_ready rises.
- Wrap: after a grant to req 3, only req 1 and req 3 valid → expect the next grant to req 1.
- Reset at t+5 of an in-flight block.
  - Expect state IDLE, busy=0, rsp_valid=0, and no response.
  - Next request is granted from rr_ptr=0.
- Watchdog (macro defined): core_res_valid forced low.
  - Expect err_timeout pulse 12 cycles after accept, return to IDLE, and no rsp_valid.
